dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between the pipelined RISC-V core's MEM stage (requester 0) and an external requester (requester 1, e.g. debug/loader).
- Sits between core and RAM: core data-port signals in, RAM `a`/`d`/`we` out, RAM `spo` back.
- Arbitration is hold-limited. Denied core accesses raise a stall. External reads return registered data with a valid strobe.

Parameters:
- ADDR_W, 10, width of the RAM address driven on mem_a_o.
- DATA_W, 32, data width.
- MAX_HOLD, 4, maximum consecutive grants to one requester while the other waits; must be ≥1.

Ports:
- clk_i in 1: clock.
- reset_i in 1: asynchronous, active-high reset.
- core_req_i in 1: core access request (load or store in MEM).
- core_we_i in 1: core store.
- core_addr_i in 32: core address (ALU result).
- core_wdata_i in DATA_W: core store data.
- core_rdata_o out DATA_W: load data (combinational from mem_spo_i).
- core_stall_o out 1: core request denied this cycle.
- ext_req_i in 1: external request.
- ext_we_i in 1: external write.
- ext_addr_i in 32: external address.
- ext_wdata_i in DATA_W: external write data.
- ext_gnt_o out 1: external granted this cycle.
- ext_rdata_o out DATA_W: registered external read data.
- ext_valid_o out 1: ext_rdata_o valid (1-cycle pulse).
- mem_a_o out ADDR_W: RAM address.
- mem_d_o out DATA_W: RAM write data.
- mem_we_o out 1: RAM write enable.
- mem_spo_i in DATA_W: RAM asynchronous read data.

Behaviour:
- State
  - owner register, 2 states: OWN_CORE / OWN_EXT.
  - hold counter, width $clog2(MAX_HOLD+1).
  - Reset values: owner=OWN_CORE, hold=0, ext_rdata_o=0, ext_valid_o=0.
- Grant (combinational from owner, hold, reqs)
  - Only one requester active → that one is granted.
  - Both active, hold<MAX_HOLD → owner granted.
  - Both active, hold==MAX_HOLD → non-owner granted.
  - Neither active → no grant.
  - At most one grant per cycle.
- Sequential update each clk_i rising edge
  - Grant given → owner ← granted requester.
  - Hold counter:
    - hold ← 1 if the owner changes.
    - Else hold ← min(hold+1, MAX_HOLD) if the other requester was also active.
    - Else hold ← 0.
  - No grant → owner unchanged, hold ← 0.
- Memory mux
  - Granted requester's addr[ADDR_W-1:0], wdata, and (we & grant) drive mem_a_o/mem_d_o/mem_we_o.
  - No grant → core fields on a/d, mem_we_o=0.
  - A write happens only on the granted cycle (RAM writes at that clk edge).
- Core side
  - core_stall_o = core_req_i & ~core_grant.
  - core_rdata_o = mem_spo_i at all times; meaningful only when granted. Same-cycle read, no added latency.
- External side
  - ext_gnt_o = ext grant.
  - Granted read (ext_we_i=0): next edge ext_rdata_o ← mem_spo_i, ext_valid_o ← 1.
  - Otherwise ext_valid_o ← 0; ext_rdata_o holds its value.
  - Granted write gives no valid pulse.
  - External requester keeps req/addr/we/wdata stable until it sees ext_gnt_o.
- Boundaries
  - Simultaneous first request after reset → core wins (owner=OWN_CORE).
  - Requester drops mid-wait → no residual priority; hold clears when idle.
  - While reset_i=1: all grants=0, mem_we_o=0, core_stall_o=0, ext_valid_o=0 asynchronously.
  - Reset mid-read → the pending valid pulse is lost.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined → adds stat_core_stall_o out 16 and stat_ext_grant_o out 16.
  - Saturating counters: +1 per cycle with core_stall_o=1, +1 per cycle with ext_gnt_o=1.
  - Saturate at 0xFFFF; reset to 0.
- Undefined → ports and counters absent; arbitration identical.

Test Plan:
- Core-only store, addr 0x10, data 0xDEADBEEF, ext idle → mem_we_o=1, mem_a_o=0x10, mem_d_o=0xDEADBEEF same cycle; core_stall_o=0.
- Ext-only read, addr 0x20, mem_spo_i=0x00001234 → cycle N: ext_gnt_o=1, mem_we_o=0; cycle N+1: ext_valid_o=1, ext_rdata_o=0x1234; cycle N+2: ext_valid_o=0.
- Both requesting continuously from reset, MAX_HOLD=4 → core granted cycles 0-3, ext granted 4-7 (core_stall_o=1 there), core granted 8-11; never both granted.
- Ext write 0xA5A5A5A5 to 0x08 requested while core idle and core_req_i asserts in the same cycle → core granted, core_stall_o=0; ext granted next cycle (hold rule), and the RAM is written only on that cycle.
- Ext owns mid-sequence, reset_i pulsed → ext_gnt_o/ext_valid_o drop immediately; after release, both requesting → core granted first.
- ARB_STATS_EN, both requesting 8 cycles from reset, MAX_HOLD=4 → stat_core_stall_o=4, stat_ext_grant_o=4. Forcing the stall counter to 0xFFFF and stalling again → it stays 0xFFFF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, async-read data RAM between the core's
// MEM stage (requester 0) and an external requester such as a debug/loader
// port (requester 1).
// Arbitration is hold-limited: with both requesting, the current owner keeps
// the RAM for at most MAX_HOLD consecutive grants, then the waiting side wins.
// Latency: core accesses complete in the granted cycle. External reads return
// data one cycle after the grant, marked by a one-cycle ext_valid_o pulse.
// Backpressure: a denied core access raises core_stall_o. The external side
// waits for ext_gnt_o and holds req/we/addr/wdata stable until it sees it.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   core_req_i/we/addr/wdata  core data-port request (load/store in MEM)
//   core_rdata_o              load data, straight from mem_spo_i
//   core_stall_o              core request denied this cycle
//   ext_req_i/we/addr/wdata   external request
//   ext_gnt_o                 external granted this cycle
//   ext_rdata_o, ext_valid_o  registered external read data + 1-cycle strobe
//   mem_a_o/d_o/we_o          RAM address, write data, write enable
//   mem_spo_i                 RAM asynchronous read data
//
// Optional feature, macro ARB_STATS_EN: adds 16-bit saturating counters
// stat_core_stall_o (cycles with core_stall_o=1) and stat_ext_grant_o
// (cycles with ext_gnt_o=1). Arbitration is the same with or without it.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // core data port
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [31:0]       core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_stall_o,
  // external requester
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [31:0]       ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_gnt_o,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              ext_valid_o,
  // RAM port
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [DATA_W-1:0] mem_d_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_spo_i
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_core_stall_o,
  output logic [15:0]       stat_ext_grant_o
`endif
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_EXT  = 1'b1
  } owner_e;

  owner_e            owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              ext_valid_q, ext_valid_d;

  logic both_req;
  logic pick_ext;
  logic core_gnt;
  logic ext_gnt;

  // Only the low ADDR_W address bits reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{core_addr_i[31:ADDR_W], ext_addr_i[31:ADDR_W]};

  // ------------------------------------------------------------------
  // Grant. Under contention the owner keeps the RAM until it has used
  // up its hold budget; at the limit the choice flips to the waiter.
  // Reset forces both grants low so nothing reaches the RAM and the
  // core sees no stall while reset is held.
  // ------------------------------------------------------------------
  assign both_req = core_req_i & ext_req_i;
  assign pick_ext = (owner_q == OWN_EXT) ^ (hold_q == HOLD_MAX);

  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (!reset_i) begin
      if (both_req) begin
        ext_gnt  = pick_ext;
        core_gnt = ~pick_ext;
      end else if (core_req_i) begin
        core_gnt = 1'b1;
      end else if (ext_req_i) begin
        ext_gnt = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Owner / hold update. hold counts consecutive grants taken while the
  // other side was waiting. An uncontested grant, or an idle cycle,
  // clears it, so a requester that drops out leaves no residual priority.
  // ------------------------------------------------------------------
  always_comb begin
    owner_d = owner_q;
    hold_d  = '0;
    if (core_gnt || ext_gnt) begin
      owner_d = ext_gnt ? OWN_EXT : OWN_CORE;
      if (owner_d != owner_q) begin
        hold_d = HOLD_ONE;
      end else if (both_req) begin
        hold_d = (hold_q == HOLD_MAX) ? HOLD_MAX : hold_q + HOLD_ONE;
      end
    end
  end

  // ------------------------------------------------------------------
  // External read return. RAM data is captured on the grant edge. Any
  // cycle without a granted external read ends the pulse, and the data
  // register keeps its last value.
  // ------------------------------------------------------------------
  always_comb begin
    ext_rdata_d = ext_rdata_q;
    ext_valid_d = ext_gnt & ~ext_we_i;
    if (ext_valid_d) begin
      ext_rdata_d = mem_spo_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner_q     <= OWN_CORE;
      hold_q      <= '0;
      ext_rdata_q <= '0;
      ext_valid_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      ext_rdata_q <= ext_rdata_d;
      ext_valid_q <= ext_valid_d;
    end
  end

  // ------------------------------------------------------------------
  // RAM mux. With no grant, the core's address and data are left on the
  // bus so a core load never sees a switch-over glitch. The write enable
  // is still gated by a grant.
  // ------------------------------------------------------------------
  assign mem_a_o  = ext_gnt ? ext_addr_i[ADDR_W-1:0] : core_addr_i[ADDR_W-1:0];
  assign mem_d_o  = ext_gnt ? ext_wdata_i : core_wdata_i;
  assign mem_we_o = (core_gnt & core_we_i) | (ext_gnt & ext_we_i);

  assign core_rdata_o = mem_spo_i;
  assign core_stall_o = core_req_i & ~core_gnt & ~reset_i;

  assign ext_gnt_o   = ext_gnt;
  assign ext_rdata_o = ext_rdata_q;
  assign ext_valid_o = ext_valid_q;

`ifdef ARB_STATS_EN
  // ------------------------------------------------------------------
  // Saturating event counters: they stick at all-ones rather than wrap.
  // ------------------------------------------------------------------
  logic [15:0] stat_stall_q, stat_stall_d;
  logic [15:0] stat_egnt_q, stat_egnt_d;

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_egnt_d  = stat_egnt_q;
    if (core_stall_o && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
    if (ext_gnt && (stat_egnt_q != 16'hFFFF)) begin
      stat_egnt_d = stat_egnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_stall_q <= '0;
      stat_egnt_q  <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_egnt_q  <= stat_egnt_d;
    end
  end

  assign stat_core_stall_o = stat_stall_q;
  assign stat_ext_grant_o  = stat_egnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized
// traffic. All results are compared against a behavioural arbitration model
// that tracks owner and hold as plain integers.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 4;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              core_req_i, core_we_i;
  logic [31:0]       core_addr_i;
  logic [DATA_W-1:0] core_wdata_i, core_rdata_o;
  logic              core_stall_o;
  logic              ext_req_i, ext_we_i;
  logic [31:0]       ext_addr_i;
  logic [DATA_W-1:0] ext_wdata_i, ext_rdata_o;
  logic              ext_gnt_o, ext_valid_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic [DATA_W-1:0] mem_d_o, mem_spo_i;
  logic              mem_we_o;
`ifdef ARB_STATS_EN
  logic [15:0]       stat_core_stall_o, stat_ext_grant_o;
`endif

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
    .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
    .ext_wdata_i(ext_wdata_i), .ext_gnt_o(ext_gnt_o), .ext_rdata_o(ext_rdata_o),
    .ext_valid_o(ext_valid_o),
    .mem_a_o(mem_a_o), .mem_d_o(mem_d_o), .mem_we_o(mem_we_o), .mem_spo_i(mem_spo_i)
`ifdef ARB_STATS_EN
    , .stat_core_stall_o(stat_core_stall_o), .stat_ext_grant_o(stat_ext_grant_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model. Owner: 0 = core, 1 = ext. Grant: -1 = none.
  int          m_owner, m_hold, m_g;
  logic [31:0] m_rdata;
  bit          m_valid;

  task automatic model_reset();
    m_owner = 0;
    m_hold  = 0;
    m_rdata = '0;
    m_valid = 0;
    m_g     = -1;
  endtask

  function automatic int model_grant();
    if (core_req_i && ext_req_i) return (m_hold < MAX_HOLD) ? m_owner : 1 - m_owner;
    if (core_req_i) return 0;
    if (ext_req_i)  return 1;
    return -1;
  endfunction

  // One clock: check combinational outputs for the current inputs,
  // step the model across the edge, then check the registered outputs.
  task automatic cycle();
    int          g;
    bit          both, ewe_now;
    logic [31:0] spo_now;
    logic [9:0]  exp_a;
    logic [31:0] exp_d;
    bit          exp_we;
    #1;
    g    = model_grant();
    m_g  = g;
    both = core_req_i && ext_req_i;
    exp_a  = (g == 1) ? ext_addr_i[9:0] : core_addr_i[9:0];
    exp_d  = (g == 1) ? ext_wdata_i : core_wdata_i;
    exp_we = (g == 0 && core_we_i) || (g == 1 && ext_we_i);
    check_val("ext_gnt",    ext_gnt_o,    g == 1);
    check_val("core_stall", core_stall_o, core_req_i && g != 0);
    check_val("mem_a",      mem_a_o,      exp_a);
    check_val("mem_d",      mem_d_o,      exp_d);
    check_val("mem_we",     mem_we_o,     exp_we);
    check_val("core_rdata", core_rdata_o, mem_spo_i);
    spo_now = mem_spo_i;
    ewe_now = ext_we_i;
    @(posedge clk_i);
    #1;
    if (g < 0) begin
      m_hold = 0;
    end else if (g != m_owner) begin
      m_owner = g;
      m_hold  = 1;
    end else if (both) begin
      m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
    end else begin
      m_hold = 0;
    end
    if (g == 1 && !ewe_now) begin
      m_valid = 1;
      m_rdata = spo_now;
    end else begin
      m_valid = 0;
    end
    check_val("ext_valid", ext_valid_o, m_valid);
    check_val("ext_rdata", ext_rdata_o, m_rdata);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    check_val("rst_ext_gnt",    ext_gnt_o,    0);
    check_val("rst_mem_we",     mem_we_o,     0);
    check_val("rst_core_stall", core_stall_o, 0);
    check_val("rst_ext_valid",  ext_valid_o,  0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    model_reset();
  endtask

  task automatic idle_inputs();
    core_req_i = 0; core_we_i = 0; core_addr_i = '0; core_wdata_i = '0;
    ext_req_i  = 0; ext_we_i  = 0; ext_addr_i  = '0; ext_wdata_i  = '0;
    mem_spo_i  = '0;
  endtask

  initial begin
    // Reset state, with both sides requesting writes while reset is held.
    idle_inputs();
    core_req_i = 1; core_we_i = 1; ext_req_i = 1; ext_we_i = 1;
    reset_i = 1'b1;
    model_reset();
    #1;
    check_val("init_ext_rdata", ext_rdata_o, 0);
    do_reset();

    // Core-only store.
    idle_inputs();
    core_req_i = 1; core_we_i = 1; core_addr_i = 32'h10; core_wdata_i = 32'hDEADBEEF;
    #1;
    check_val("cst_we",    mem_we_o,     1);
    check_val("cst_a",     mem_a_o,      10'h10);
    check_val("cst_d",     mem_d_o,      32'hDEADBEEF);
    check_val("cst_stall", core_stall_o, 0);
    cycle();

    // External-only read.
    idle_inputs();
    ext_req_i = 1; ext_addr_i = 32'h20; mem_spo_i = 32'h00001234;
    #1;
    check_val("erd_gnt", ext_gnt_o, 1);
    check_val("erd_we",  mem_we_o,  0);
    cycle();
    idle_inputs();
    check_val("erd_valid1", ext_valid_o, 1);
    check_val("erd_data",   ext_rdata_o, 32'h1234);
    cycle();
    check_val("erd_valid2", ext_valid_o, 0);

    // Both requesting continuously from reset: 4 core, 4 ext, 4 core.
    do_reset();
    core_req_i = 1; ext_req_i = 1; ext_addr_i = 32'h44;
    for (int i = 0; i < 12; i++) begin
      mem_spo_i = $urandom;
`ifdef ARB_STATS_EN
      if (i == 8) begin
        check_val("stat_stall", stat_core_stall_o, 4);
        check_val("stat_egnt",  stat_ext_grant_o,  4);
      end
`endif
      #1;
      check_val("rr_ext_gnt", ext_gnt_o,    (i >= 4 && i < 8));
      check_val("rr_stall",   core_stall_o, (i >= 4 && i < 8));
      cycle();
    end

    // Ext write arrives with a same-cycle core load: core first, ext next.
    do_reset();
    idle_inputs();
    cycle();
    core_req_i = 1; core_addr_i = 32'h30;
    ext_req_i = 1; ext_we_i = 1; ext_addr_i = 32'h08; ext_wdata_i = 32'hA5A5A5A5;
    #1;
    check_val("ew_stall0", core_stall_o, 0);
    check_val("ew_gnt0",   ext_gnt_o,    0);
    check_val("ew_we0",    mem_we_o,     0);
    cycle();
    core_req_i = 0;
    #1;
    check_val("ew_gnt1", ext_gnt_o, 1);
    check_val("ew_we1",  mem_we_o,  1);
    check_val("ew_a1",   mem_a_o,   10'h08);
    check_val("ew_d1",   mem_d_o,   32'hA5A5A5A5);
    cycle();
    ext_req_i = 0;
    #1;
    check_val("ew_we2", mem_we_o, 0);
    cycle();

    // Reset while ext owns and a read return is pending.
    idle_inputs();
    ext_req_i = 1; ext_addr_i = 32'h55; mem_spo_i = 32'hCAFE0001;
    cycle();
    check_val("rm_valid_pre", ext_valid_o, 1);
    core_req_i = 1;
    #1;
    check_val("rm_gnt_pre", ext_gnt_o, 1);
    do_reset();
    #1;
    check_val("rm_first_gnt", ext_gnt_o,    0);
    check_val("rm_first_stl", core_stall_o, 0);
    cycle();

    // Randomized traffic; the external side honours its hold-until-grant rule.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      core_req_i   = ($urandom_range(0, 9) < 6);
      core_we_i    = $urandom_range(0, 1);
      core_addr_i  = $urandom;
      core_wdata_i = $urandom;
      if (!ext_req_i || m_g == 1) begin
        ext_req_i   = ($urandom_range(0, 9) < 5);
        ext_we_i    = $urandom_range(0, 1);
        ext_addr_i  = $urandom;
        ext_wdata_i = $urandom;
      end
      mem_spo_i = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
